// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared exception state, address-mux select and cause codes
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } state_e;

  // Address-mux select codes, shared with the mux and the control unit.
  localparam logic [2:0] SEL_INSTR   = 3'b000;
  localparam logic [2:0] SEL_EXC_OPC = 3'b011;
  localparam logic [2:0] SEL_EXC_OVF = 3'b100;
  localparam logic [2:0] SEL_EXC_DIV = 3'b101;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;

endpackage

// File: rtl/exc_priority_enc.sv
// rtl/exc_priority_enc.sv - fixed-priority encoder from exception events to cause and vector select
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic       req_valid,
  output logic [1:0] req_cause,
  output logic [2:0] req_sel
);

  always_comb begin
    req_valid = 1'b1;
    req_cause = CAUSE_NONE;
    req_sel   = SEL_INSTR;
    if (exc_opcode) begin
      req_cause = CAUSE_OPC;
      req_sel   = SEL_EXC_OPC;
    end else if (exc_ovf) begin
      req_cause = CAUSE_OVF;
      req_sel   = SEL_EXC_OVF;
    end else if (exc_div0) begin
      req_cause = CAUSE_DIV;
      req_sel   = SEL_EXC_DIV;
    end else begin
      req_valid = 1'b0;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - multicycle exception handler: save EPC, fetch vector byte, load PC
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] PC_OFFSET   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic        mux_own,
  output logic [2:0]  mem_sel,
  output logic        mem_rd,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        pc_we,
  output logic [31:0] pc_out,
  output logic [1:0]  cause
);

  localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;

  logic       req_valid;
  logic [1:0] req_cause;
  logic [2:0] req_sel;
  logic       busy;

  exc_priority_enc u_prio (
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .req_valid  (req_valid),
    .req_cause  (req_cause),
    .req_sel    (req_sel)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= SEL_INSTR;
      cause_q <= CAUSE_NONE;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // Events are only sampled in IDLE; anything arriving while busy is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ADDR;
          sel_d   = req_sel;
          cause_d = req_cause;
          epc_d   = pc_in - PC_OFFSET;
        end
      end
      ADDR: begin
        cnt_d   = CNT_LOAD;
        state_d = (MEM_LATENCY > 1) ? WAIT : LOAD;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state so a reset edge clears them immediately.
  always_comb begin
    busy    = (state_q != IDLE);
    mux_own = busy;
    mem_rd  = busy;
    mem_sel = busy ? sel_q : SEL_INSTR;
    epc_we  = (state_q == ADDR);
    pc_we   = (state_q == LOAD);
    pc_out  = pc_we ? (mem_rdata & 32'h0000_00FF) : 32'h0;
    epc_out = epc_q;
    cause   = cause_q;
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - self-checking bench for exception_sequencer at latencies 2 and 1
module tb_exception_sequencer;
  import exc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem [0:255];

  logic        mux_own_o [2];
  logic [2:0]  mem_sel_o [2];
  logic        mem_rd_o  [2];
  logic        epc_we_o  [2];
  logic [31:0] epc_out_o [2];
  logic        pc_we_o   [2];
  logic [31:0] pc_out_o  [2];
  logic [1:0]  cause_o   [2];
  logic [31:0] rdata0, rdata1;

  logic [7:0] a0_p0 = 8'd0, a0_p1 = 8'd0, a1_p0 = 8'd0;

  function automatic logic [7:0] sel_addr(input logic [2:0] s);
    case (s)
      3'b011:  return 8'd253;
      3'b100:  return 8'd254;
      3'b101:  return 8'd255;
      default: return 8'd0;
    endcase
  endfunction

  // Memory with a registered address pipeline as deep as each instance's latency.
  always @(posedge clk) begin
    a0_p0 <= sel_addr(mem_sel_o[0]);
    a0_p1 <= a0_p0;
    a1_p0 <= sel_addr(mem_sel_o[1]);
  end
  assign rdata0 = mem[a0_p1];
  assign rdata1 = mem[a1_p0];

  exception_sequencer #(.MEM_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_rdata(rdata0), .mux_own(mux_own_o[0]), .mem_sel(mem_sel_o[0]),
    .mem_rd(mem_rd_o[0]), .epc_we(epc_we_o[0]), .epc_out(epc_out_o[0]), .pc_we(pc_we_o[0]),
    .pc_out(pc_out_o[0]), .cause(cause_o[0])
  );

  exception_sequencer #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_rdata(rdata1), .mux_own(mux_own_o[1]), .mem_sel(mem_sel_o[1]),
    .mem_rd(mem_rd_o[1]), .epc_we(epc_we_o[1]), .epc_out(epc_out_o[1]), .pc_we(pc_we_o[1]),
    .pc_out(pc_out_o[1]), .cause(cause_o[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one sequence occupies cycles start..start+L, nothing else.
  int          lat [2] = '{2, 1};
  bit          act [2] = '{1'b0, 1'b0};
  int          start [2];
  int          m_vec [2];
  logic [1:0]  m_cause [2] = '{2'b00, 2'b00};
  logic [31:0] m_epc [2] = '{32'h0, 32'h0};
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  function automatic logic [2:0] vec_sel(input int v);
    if (v == 253) return 3'b011;
    if (v == 254) return 3'b100;
    if (v == 255) return 3'b101;
    return 3'b000;
  endfunction

  task automatic step();
    bit busy, e_we, p_we;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      busy = act[k] && (cyc >= start[k]) && (cyc <= start[k] + lat[k]);
      e_we = act[k] && (cyc == start[k]);
      p_we = act[k] && (cyc == start[k] + lat[k]);
      chk($sformatf("c%0d_L%0d_mux_own", cyc, lat[k]), 32'(mux_own_o[k]), 32'(busy));
      chk($sformatf("c%0d_L%0d_mem_rd", cyc, lat[k]), 32'(mem_rd_o[k]), 32'(busy));
      chk($sformatf("c%0d_L%0d_mem_sel", cyc, lat[k]), 32'(mem_sel_o[k]),
          busy ? 32'(vec_sel(m_vec[k])) : 32'h0);
      chk($sformatf("c%0d_L%0d_epc_we", cyc, lat[k]), 32'(epc_we_o[k]), 32'(e_we));
      chk($sformatf("c%0d_L%0d_pc_we", cyc, lat[k]), 32'(pc_we_o[k]), 32'(p_we));
      chk($sformatf("c%0d_L%0d_pc_out", cyc, lat[k]), pc_out_o[k],
          p_we ? {24'h0, mem[m_vec[k]][7:0]} : 32'h0);
      chk($sformatf("c%0d_L%0d_epc_out", cyc, lat[k]), epc_out_o[k], m_epc[k]);
      chk($sformatf("c%0d_L%0d_cause", cyc, lat[k]), 32'(cause_o[k]), 32'(m_cause[k]));
    end
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        act[k] = 1'b0; m_cause[k] = 2'b00; m_epc[k] = 32'h0;
      end else if (act[k]) begin
        if (cyc == start[k] + lat[k]) act[k] = 1'b0;
      end else if (exc_opcode || exc_ovf || exc_div0) begin
        act[k]   = 1'b1;
        start[k] = cyc + 1;
        m_epc[k] = pc_in - 32'd4;
        if (exc_opcode)   begin m_cause[k] = 2'b01; m_vec[k] = 253; end
        else if (exc_ovf) begin m_cause[k] = 2'b10; m_vec[k] = 254; end
        else              begin m_cause[k] = 2'b11; m_vec[k] = 255; end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b0; exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0; pc_in = 32'h0;
    @(posedge clk);
    #1;
    idle_steps(2);
    reset = 1'b1;
    idle_steps(1);

    // Overflow pulse, upper rdata bytes all ones.
    mem[254] = 32'hFFFF_FF9C;
    pc_in = 32'h0000_0040; exc_ovf = 1'b1;
    step();
    exc_ovf = 1'b0;
    idle_steps(5);
    chk("dir_ovf_cause", 32'(cause_o[0]), 32'h2);
    chk("dir_ovf_epc", epc_out_o[0], 32'h0000_003C);

    // Opcode and div0 together: opcode wins, div0 dropped.
    pc_in = 32'h0000_0100; exc_opcode = 1'b1; exc_div0 = 1'b1;
    step();
    exc_opcode = 1'b0; exc_div0 = 1'b0;
    idle_steps(5);
    chk("dir_opc_cause", 32'(cause_o[0]), 32'h1);

    // Div0 with wrapping EPC.
    mem[255] = 32'h1234_56F0;
    pc_in = 32'h0000_0000; exc_div0 = 1'b1;
    step();
    exc_div0 = 1'b0;
    idle_steps(5);
    chk("dir_wrap_epc", epc_out_o[1], 32'hFFFF_FFFC);
    chk("dir_div_cause", 32'(cause_o[1]), 32'h3);

    // Overflow held high across several sequences.
    pc_in = 32'h0000_2000; exc_ovf = 1'b1;
    idle_steps(9);
    exc_ovf = 1'b0;
    idle_steps(4);

    // Reset held three cycles while the L=2 instance sits in WAIT.
    pc_in = 32'h0000_0800; exc_ovf = 1'b1;
    step();
    exc_ovf = 1'b0;
    step();
    reset = 1'b0;
    idle_steps(3);
    chk("dir_rst_cause", 32'(cause_o[0]), 32'h0);
    chk("dir_rst_epc", epc_out_o[0], 32'h0);
    reset = 1'b1;
    idle_steps(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      exc_opcode = ($urandom_range(0, 7) == 0);
      exc_ovf    = ($urandom_range(0, 5) == 0);
      exc_div0   = ($urandom_range(0, 5) == 0);
      pc_in      = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      reset      = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 15) == 0) mem[$urandom_range(253, 255)] = $urandom;
      step();
    end
    reset = 1'b1; exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
    idle_steps(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
